// File: rtl/spi_slave_regbus.sv
// SPI mode-0 slave to register-bus bridge: oversampled SPI pins, even-parity header, same-frame read data.
// Define SPI_BURST_EN to let a frame carry consecutive data words at auto-incrementing addresses.
module spi_slave_regbus #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 8,
  parameter int RD_LAT      = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              spi_clk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W-1:0] address,
  output logic              write_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              read_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int HDR_W = 2 + ADDR_W;
  localparam int MAX_W = (HDR_W > DATA_W) ? HDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W);
  localparam int LAT_W = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {IDLE, HDR, RD_FETCH, DATA, DONE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_reg, csn_sync_reg, mosi_sync_reg;
  logic spi_rise, spi_fall, cs_fall, cs_rise, mosi_bit;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [HDR_W-1:0]  hdr_sr_reg, hdr_sr_next;
  logic [DATA_W-1:0] data_sr_reg, data_sr_next;
  logic [DATA_W-1:0] shift_out_reg, shift_out_next;
  logic              miso_reg, miso_next;
  logic [ADDR_W-1:0] address_reg, address_next;
  logic [DATA_W-1:0] wr_data_reg, wr_data_next;
  logic              write_en_reg, write_en_next;
  logic              wr_pend_reg, wr_pend_next;
  logic              read_en_reg, read_en_next;
  logic              rd_pend_reg, rd_pend_next;
  logic [LAT_W-1:0]  lat_cnt_reg, lat_cnt_next;
  logic              parity_err_reg, parity_err_next;
  logic              frame_err_reg, frame_err_next;
  logic              rw_reg, rw_next;
  logic              word_done_reg, word_done_next;

  logic [HDR_W-1:0]  hdr_word;
  logic [DATA_W-1:0] data_word;
  logic              pending;
  logic              completing;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_reg <= '0;
      csn_sync_reg  <= '1;
      mosi_sync_reg <= '0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_clk};
      csn_sync_reg  <= {csn_sync_reg[SYNC_STAGES-2:0], cs_n};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
    end
  end

  // Edges compare the two oldest stages; mosi is taken from the same stage as the new spi_clk level.
  assign spi_rise = sclk_sync_reg[SYNC_STAGES-2] & ~sclk_sync_reg[SYNC_STAGES-1];
  assign spi_fall = ~sclk_sync_reg[SYNC_STAGES-2] & sclk_sync_reg[SYNC_STAGES-1];
  assign cs_fall  = ~csn_sync_reg[SYNC_STAGES-2] & csn_sync_reg[SYNC_STAGES-1];
  assign cs_rise  = csn_sync_reg[SYNC_STAGES-2] & ~csn_sync_reg[SYNC_STAGES-1];
  assign mosi_bit = mosi_sync_reg[SYNC_STAGES-2];

  assign hdr_word  = {hdr_sr_reg[HDR_W-2:0], mosi_bit};
  assign data_word = {data_sr_reg[DATA_W-2:0], mosi_bit};

  // A frame is cut short unless the chip select rises on a word boundary after a finished word.
  assign pending = (state_reg == HDR) ||
                   (((state_reg == RD_FETCH) || (state_reg == DATA)) &&
                    ((bit_cnt_reg != '0) || !word_done_reg));

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    hdr_sr_next     = hdr_sr_reg;
    data_sr_next    = data_sr_reg;
    shift_out_next  = shift_out_reg;
    miso_next       = miso_reg;
    address_next    = address_reg;
    wr_data_next    = wr_data_reg;
    rw_next         = rw_reg;
    word_done_next  = word_done_reg;
    lat_cnt_next    = lat_cnt_reg;
    wr_pend_next    = 1'b0;
    write_en_next   = wr_pend_reg;
    rd_pend_next    = 1'b0;
    read_en_next    = rd_pend_reg;
    parity_err_next = 1'b0;
    frame_err_next  = 1'b0;
    completing      = 1'b0;

    if (read_en_reg) begin
      lat_cnt_next = LAT_W'(1);
    end else if (lat_cnt_reg != '0) begin
      lat_cnt_next = (lat_cnt_reg == LAT_W'(RD_LAT)) ? '0 : lat_cnt_reg + LAT_W'(1);
    end

    case (state_reg)
      IDLE: begin
        if (cs_fall) begin
          state_next     = HDR;
          bit_cnt_next   = '0;
          hdr_sr_next    = '0;
          data_sr_next   = '0;
          shift_out_next = '0;
          word_done_next = 1'b0;
          miso_next      = 1'b0;
        end
      end
      HDR: begin
        if (spi_rise) begin
          hdr_sr_next = hdr_word;
          if (bit_cnt_reg == CNT_W'(HDR_W - 1)) begin
            bit_cnt_next = '0;
            if (^hdr_word) begin
              parity_err_next = 1'b1;
              state_next      = DONE;
            end else begin
              address_next = hdr_word[ADDR_W-1:0];
              rw_next      = hdr_word[HDR_W-1];
              if (hdr_word[HDR_W-1]) begin
                rd_pend_next = 1'b1;
                state_next   = RD_FETCH;
              end else begin
                state_next = DATA;
              end
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end else if (spi_fall) begin
          miso_next = 1'b0;
        end
      end
      RD_FETCH: begin
        if (lat_cnt_reg == LAT_W'(RD_LAT)) begin
          shift_out_next = rd_data;
          state_next     = DATA;
        end
      end
      DATA: begin
        if (spi_rise) begin
          data_sr_next = data_word;
          if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
            bit_cnt_next   = '0;
            word_done_next = 1'b1;
            completing     = 1'b1;
            if (!rw_reg) begin
              wr_data_next = data_word;
              wr_pend_next = 1'b1;
            end
`ifdef SPI_BURST_EN
            if (!cs_rise) begin
              address_next = address_reg + ADDR_W'(1);
              if (rw_reg) begin
                rd_pend_next = 1'b1;
                state_next   = RD_FETCH;
              end
            end
`else
            state_next = DONE;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end else if (spi_fall) begin
          if (rw_reg) begin
            miso_next      = shift_out_reg[DATA_W-1];
            shift_out_next = {shift_out_reg[DATA_W-2:0], 1'b0};
          end else begin
            miso_next = 1'b0;
          end
        end
      end
      DONE: begin
        miso_next = 1'b0;
      end
      default: state_next = IDLE;
    endcase

    if (cs_rise) begin
      state_next   = IDLE;
      miso_next    = 1'b1;
      rd_pend_next = 1'b0;
      if (pending && !completing) begin
        frame_err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      hdr_sr_reg     <= '0;
      data_sr_reg    <= '0;
      shift_out_reg  <= '0;
      miso_reg       <= 1'b1;
      address_reg    <= '0;
      wr_data_reg    <= '0;
      write_en_reg   <= 1'b0;
      wr_pend_reg    <= 1'b0;
      read_en_reg    <= 1'b0;
      rd_pend_reg    <= 1'b0;
      lat_cnt_reg    <= '0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      rw_reg         <= 1'b0;
      word_done_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      hdr_sr_reg     <= hdr_sr_next;
      data_sr_reg    <= data_sr_next;
      shift_out_reg  <= shift_out_next;
      miso_reg       <= miso_next;
      address_reg    <= address_next;
      wr_data_reg    <= wr_data_next;
      write_en_reg   <= write_en_next;
      wr_pend_reg    <= wr_pend_next;
      read_en_reg    <= read_en_next;
      rd_pend_reg    <= rd_pend_next;
      lat_cnt_reg    <= lat_cnt_next;
      parity_err_reg <= parity_err_next;
      frame_err_reg  <= frame_err_next;
      rw_reg         <= rw_next;
      word_done_reg  <= word_done_next;
    end
  end

  assign miso       = miso_reg;
  assign address    = address_reg;
  assign wr_data    = wr_data_reg;
  assign write_en   = write_en_reg;
  assign read_en    = read_en_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = (state_reg != IDLE);

endmodule
